// File: rtl/vol_pkg.sv
// Shared types and default parameters for the volume arbiter.
// Includes a helper that sizes requester-index signals.
package vol_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int N_DEF     = 20000;
    localparam int CBITS_DEF = 15;
    localparam int NREQ_DEF  = 4;
    localparam int TMAX_DEF  = 16;

    // Width of a requester index; never narrower than one bit.
    function automatic int id_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/vol_arbiter_rr_pick.sv
// Combinational round-robin picker: the first eligible index after last,
// searching cyclically. valid is low when nothing is eligible.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] elig,
    input  logic [IW-1:0]   last,
    output logic [IW-1:0]   win,
    output logic            valid
);

    always_comb begin
        int idx;
        win   = '0;
        valid = 1'b0;
        idx   = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = int'(last) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!valid && elig[idx[IW-1:0]]) begin
                valid = 1'b1;
                win   = idx[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/vol_arbiter.sv
// Round-robin owner of the shared volume register; each grant steps vol
// by one per cycle in the latched direction, bounded by a hold limit.
//
// state | meaning
// IDLE  | no grant; arbitrate among eligible requesters
// FILL  | granted requester increments vol each cycle
// DRAIN | granted requester decrements vol each cycle
module vol_arbiter
    import vol_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int CBITS = CBITS_DEF,
    parameter int NREQ  = NREQ_DEF,
    parameter int TMAX  = TMAX_DEF,
    localparam int IW   = id_w(NREQ),
    localparam int HW   = $clog2(TMAX + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NREQ-1:0]  req,
    input  logic [NREQ-1:0]  dir,
    output logic [NREQ-1:0]  gnt,
    output logic [CBITS-1:0] vol,
    output logic             full,
    output logic             empty,
    output logic             done,
    output logic [IW-1:0]    done_id
);

    state_t          state;
    logic [IW-1:0]   g;
    logic [IW-1:0]   last;
    logic [HW-1:0]   hold;
    logic [NREQ-1:0] elig;
    logic [IW-1:0]   win;
    logic            win_valid;
    logic            at_bound;
    logic            stop;

    assign full  = (vol == CBITS'(N));
    assign empty = (vol == '0);

    // A requester that would push vol past a boundary is not eligible.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            elig[i] = req[i] && !(dir[i] && full) && !(!dir[i] && empty);
        end
    end

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr_pick (
        .elig  (elig),
        .last  (last),
        .win   (win),
        .valid (win_valid)
    );

    assign at_bound = (state == FILL) ? full : empty;
    assign stop     = !req[g] || at_bound || (hold == HW'(TMAX));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            vol     <= '0;
            gnt     <= '0;
            done    <= 1'b0;
            done_id <= '0;
            hold    <= '0;
            g       <= '0;
            last    <= IW'(NREQ - 1);
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (win_valid) begin
                        gnt   <= {{(NREQ-1){1'b0}}, 1'b1} << win;
                        g     <= win;
                        hold  <= '0;
                        state <= dir[win] ? FILL : DRAIN;
                    end else begin
                        gnt <= '0;
                    end
                end
                FILL, DRAIN: begin
                    if (stop) begin
                        gnt     <= '0;
                        done    <= 1'b1;
                        done_id <= g;
                        last    <= g;
                        state   <= IDLE;
                    end else begin
                        vol  <= (state == FILL) ? vol + CBITS'(1) : vol - CBITS'(1);
                        hold <= hold + HW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/vol_arbiter.md
# vol_arbiter

Round-robin scheduler that shares the single volume-counter resource among NREQ requesters, each of which wants to fill (increment) or drain (decrement) it. It sits between the requester agents and the volume resource. It owns the volume register and clamps it to [0, N]. It bounds each grant with a hold limit so that no requester can starve the others.

## Interface
- N, 20000: volume capacity; vol never exceeds N.
- CBITS, 15: vol width; 2^CBITS > N required.
- NREQ, 4: number of requesters (2..8).
- TMAX, 16: maximum steps per grant (≥1).

- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset (one clock domain).
- req  in  NREQ  per-requester request level.
- dir  in  NREQ  per-requester direction: 1 = fill, 0 = drain. Sampled only at grant.
- gnt  out  NREQ  one-hot grant, registered.
- vol  out  CBITS  current volume, registered.
- full  out  1  vol == N.
- empty  out  1  vol == 0.
- done  out  1  one-cycle pulse when a grant ends.
- done_id  out  clog2(NREQ)  index of the requester whose grant just ended; valid with done.

## Operation
- States: IDLE, FILL, DRAIN.
- **Reset values** (rst low, asynchronous):
  - state = IDLE, vol = 0, gnt = 0, done = 0, done_id = 0.
  - hold counter = 0.
  - last = NREQ-1, so requester 0 has first priority.
- **IDLE:**
  - Eligible requesters: req[i] && !(dir[i] && full) && !(!dir[i] && empty).
  - The winner is the first eligible index after last, searching cyclically.
  - The winner's dir is latched. On the next edge: gnt = onehot(winner), state = FILL or DRAIN, hold = 0.
  - If no requester is eligible, stay in IDLE with gnt = 0.
- **FILL/DRAIN**, evaluated at each edge for granted index g. End the grant, without stepping, if any of these holds:
  - req[g] == 0
  - FILL and vol == N
  - DRAIN and vol == 0
  - hold == TMAX
- **Otherwise:** vol ±1 and hold +1.
- **End of grant:** gnt = 0, done = 1, done_id = g, last = g, state = IDLE.
- **Ignored inputs while granted:**
  - dir changes on the granted requester.
  - req on non-granted requesters (they wait).
- **Arithmetic:**
  - vol stays unsigned and saturates at 0 and N; it never wraps.
  - The hold counter is clog2(TMAX+1) bits wide.
- **Reset mid-grant:** immediate return to the reset values. The partial grant is lost and no done pulse is issued.

## Timing
- **Grant latency:** req is seen in IDLE in cycle t; gnt is high from t+1.
- **First step:** vol changes at the end of cycle t+1.
- **Grant length:** at most TMAX steps, so gnt is high for at most TMAX+1 cycles. The final cycle is the termination check.
- **done:** high for exactly one cycle, in the IDLE cycle after the grant.
- **Back-to-back grants:** arbitration runs during that same cycle, so the next gnt can rise one cycle after done. There is exactly one gnt-low cycle between grants.
- **Flags:** full and empty are derived from the vol register and carry no extra latency.
- **Simultaneous events:** if req[g] falls in the same cycle that the boundary is reached, the grant ends once, with a single done pulse.

## Structure
- Package vol_pkg holds:
  - the state enum (IDLE, FILL, DRAIN);
  - default N, CBITS, NREQ and TMAX;
  - the id-width helper.
- Sub-module rr_pick: combinational round-robin picker. Inputs: eligible mask and last. Outputs: winner index and valid. It is instantiated once; the FSM, counters and vol register stay in vol_arbiter.

## Test plan
- **Single fill:** vol = 0, TMAX = 8, req[0] = 1 with dir = 1 held high → gnt = 0001 for 9 cycles, vol = 8, done with done_id = 0, then regrant after 1 gap cycle.
- **Round-robin:** req = 0011, both fill, TMAX = 4 → grants alternate 0, 1, 0, 1. vol increases by 4 per grant.
- **Upper boundary:** vol = N-2, fill grant → exactly 2 steps, vol = 20000, full = 1, done. A subsequent fill request is masked and gnt stays 0.
- **Empty masking:** vol = 0, req[2] drain and req[3] fill → req[2] is skipped, gnt = 1000.
- **Early release:** req[1] drops after 3 steps → vol changes by 3, done_id = 1, one done pulse.
- **Reset mid-operation:** rst low during a DRAIN at vol = 500 → vol = 0, gnt = 0, done = 0 asynchronously. After release, requester 0 has priority.
